// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and instruction buffer between imem and decode
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  output logic [31:0]   op_instr_addr_from_proc,
  input  logic [31:0]   ip_instr_from_imem,
  input  logic          ip_instr_valid,
  input  logic          ip_redirect_valid,
  input  logic [31:0]   ip_redirect_pc,
  input  logic          ip_deq_ready,
  output logic          op_instr_valid,
  output logic [31:0]   op_instr,
  output logic [31:0]   op_instr_pc,
  output logic          op_halted,
  output logic [CW-1:0] op_count
);
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          halt_q, halt_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   in_mem_q [DEPTH];
  logic          pop, accept, push, eop;
  assign op_instr_valid          = cnt_q != '0;
  assign op_instr                = op_instr_valid ? in_mem_q[rp_q] : 32'd0;
  assign op_instr_pc             = op_instr_valid ? pc_mem_q[rp_q] : 32'd0;
  assign op_halted               = halt_q;
  assign op_count                = cnt_q;
  assign op_instr_addr_from_proc = pc_q;
  // A redirect suppresses both the pop and the fetch so the flush wins cleanly
  assign pop    = op_instr_valid & ip_deq_ready & ~ip_redirect_valid;
  assign accept = ~halt_q & ip_instr_valid & ((cnt_q != FULL) | pop) & ~ip_redirect_valid;
  assign push   = accept & (ip_instr_from_imem != 32'd0);
  assign eop    = accept & (ip_instr_from_imem == 32'd0);
  // Next-state: redirect flushes everything, otherwise push/pop/advance
  always_comb begin
    pc_d   = ip_redirect_valid ? {ip_redirect_pc[31:2], 2'b00} : (push ? pc_q + 32'd4 : pc_q);
    halt_d = ip_redirect_valid ? 1'b0 : (halt_q | eop);
    rp_d   = ip_redirect_valid ? '0 : (pop ? rp_q + AW'(1) : rp_q);
    wp_d   = ip_redirect_valid ? '0 : (push ? wp_q + AW'(1) : wp_q);
    cnt_d  = ip_redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      halt_q <= 1'b0;
      rp_q   <= '0;
      wp_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
      rp_q   <= rp_d;
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
    end
  end
  // Entry storage: contents are don't-care until the count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wp_q] <= pc_q;
      in_mem_q[wp_q] <= ip_instr_from_imem;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against a queue model
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, in_word, rpc, h_instr, h_pc;
  logic        in_v, redir, rdy, h_valid, halted;
  logic [2:0]  count;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];

  fetch_queue #(.RESET_PC(32'h0), .DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .op_instr_addr_from_proc(addr),
    .ip_instr_from_imem(in_word), .ip_instr_valid(in_v),
    .ip_redirect_valid(redir), .ip_redirect_pc(rpc),
    .ip_deq_ready(rdy),
    .op_instr_valid(h_valid), .op_instr(h_instr), .op_instr_pc(h_pc),
    .op_halted(halted), .op_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    logic [31:0] e_in, e_pc;
    e_in = q_in.size() ? q_in[0] : 32'd0;
    e_pc = q_pc.size() ? q_pc[0] : 32'd0;
    chk("count", 32'(count), 32'(q_in.size()));
    chk("valid", 32'(h_valid), 32'(q_in.size() != 0));
    chk("head_instr", h_instr, e_in);
    chk("head_pc", h_pc, e_pc);
    chk("halted", 32'(halted), 32'(m_halt));
    chk("addr", addr, m_pc);
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_in.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
  endtask

  // one clock: drive at negedge, advance model by the rules, check at next negedge
  task automatic cyc(input logic v, input logic [31:0] w, input logic r,
                     input logic [31:0] rp, input logic rd);
    bit p, a;
    in_v = v; in_word = w; redir = r; rpc = rp; rdy = rd;
    if (r) begin
      q_pc.delete();
      q_in.delete();
      m_pc   = {rp[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      p = q_in.size() > 0 && rd;
      a = !m_halt && v && (q_in.size() < 4 || p);
      if (p) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (a && w != 0) begin
        q_pc.push_back(m_pc);
        q_in.push_back(w);
        m_pc = m_pc + 32'd4;
      end else if (a) m_halt = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk_model();
  endtask

  function automatic logic [31:0] prog(input logic [31:0] pc);
    return pc < 12 ? 32'h11 * (pc / 4 + 1) : 32'h0;
  endfunction

  initial begin
    rst = 1'b0; in_v = 0; in_word = 0; redir = 0; rpc = 0; rdy = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(h_valid), 32'd0);
    chk("rst_instr", h_instr, 32'd0);
    chk("rst_pc", h_pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", addr, 32'h0);
    rst = 1'b1;
    // stream 0x11,0x22,0x33 then the end-of-program word
    for (int i = 0; i < 6; i++) cyc(1, prog(m_pc), 0, 0, 1);
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_pc", addr, 32'd12);
    chk("halt_empty", 32'(h_valid), 32'd0);
    // halt then redirect restarts fetch at 0x8
    cyc(1, 32'hAA, 1, 32'h8, 1);
    chk("redir_unhalt", 32'(halted), 32'd0);
    chk("redir_pc8", addr, 32'h8);
    cyc(0, 32'hBB, 0, 0, 0);
    cyc(0, 32'hBB, 0, 0, 0);
    chk("imem_invalid_hold", addr, 32'h8);
    chk("imem_invalid_empty", 32'(count), 32'd0);
    // backpressure until full
    cyc(0, 0, 1, 32'h0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 32'h100 + m_pc, 0, 0, 0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_pc", addr, 32'd16);
    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + m_pc, 0, 0, 1);
    chk("pushpop_count", 32'(count), 32'd4);
    chk("pushpop_pc", addr, 32'd32);
    cyc(0, 0, 0, 0, 1);
    chk("three_left", 32'(count), 32'd3);
    // redirect flush with deq_ready high
    cyc(1, 32'h55, 1, 32'h43, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_pc", addr, 32'h40);
    cyc(1, 32'h77, 0, 0, 0);
    chk("after_flush_head", h_pc, 32'h40);
    // PC wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap_start", addr, 32'hFFFF_FFFC);
    cyc(1, 32'h99, 0, 0, 0);
    chk("wrap_pc", addr, 32'h0);
    // random traffic
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1),
          $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 2) != 0);
    // async reset between edges with three entries queued
    cyc(0, 0, 1, 32'h200, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h300 + m_pc, 0, 0, 0);
    chk("pre_areset_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_valid", 32'(h_valid), 32'd0);
    chk("areset_addr", addr, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++)
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1),
          $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 1) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
